// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: byte UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is
// defined). It has a 2-flop input synchronizer, mid-bit start validation and a
// stop-bit framing check. Each received byte goes into a one-entry holding
// register with a valid/ack handshake.
module uart_rx_buffered #(
  parameter int c_CYCLES_PER_BIT = 217
) (
  input  logic       i_CLK,
  input  logic       i_RESET_n,
  input  logic       i_SERIAL_DATA,
  input  logic       i_RX_ACK,
  output logic [7:0] o_DATA_RX,
  output logic       o_RX_DATA_VALID,
  output logic       o_FRAME_ERR,
  output logic       o_PARITY_ERR,
  output logic       o_OVERRUN,
  output logic       o_RX_BUSY
);
  localparam int N  = c_CYCLES_PER_BIT;
  localparam int H  = (N - 1) / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  // START is entered on the detect edge, so the start resample lands H edges after entry
  localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            s1, s2, s;
  logic            deliver, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic            par_bad, par_bad_n, perr_n;
`endif

  assign s         = s2;
  assign o_RX_BUSY = (state != IDLE);

  // two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= i_SERIAL_DATA;
      s2 <= s1;
    end
  end

  // receive FSM state, bit timer, bit index and shift register
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  // latched parity verdict, consumed when the stop bit is sampled
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) par_bad <= 1'b0;
    else            par_bad <= par_bad_n;
  end
`endif

  // next-state logic: bit sampling, framing decisions and delivery request
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    deliver = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE:  if (!s) state_n = START;
      START: if (cnt == CNT_MID) state_n = s ? IDLE : DATA;
      DATA: if (cnt == CNT_LAST) begin
        shreg_n[idx] = s;
        cnt_n        = '0;
        idx_n        = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == CNT_LAST) begin
        par_bad_n = s ^ (^shreg);
        state_n   = STOP;
      end
`endif
      STOP: if (cnt == CNT_LAST) begin
`ifdef UART_RX_PARITY_EN
        perr_n  = par_bad;
        deliver = s & ~par_bad;
`else
        deliver = s;
`endif
        ferr_n  = ~s;
        state_n = s ? IDLE : BRK;
      end
      BRK:   if (s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end

  // holding register, handshake and one-cycle status pulses
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      o_DATA_RX       <= '0;
      o_RX_DATA_VALID <= 1'b0;
      o_FRAME_ERR     <= 1'b0;
      o_OVERRUN       <= 1'b0;
    end else begin
      o_FRAME_ERR <= ferr_n;
      o_OVERRUN   <= deliver & o_RX_DATA_VALID & ~i_RX_ACK;
      if (deliver && (!o_RX_DATA_VALID || i_RX_ACK)) begin
        o_DATA_RX       <= shreg;
        o_RX_DATA_VALID <= 1'b1;
      end else if (i_RX_ACK) begin
        o_RX_DATA_VALID <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity error pulse, aligned with the stop-bit decision
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) o_PARITY_ERR <= 1'b0;
    else            o_PARITY_ERR <= perr_n;
  end
`else
  assign o_PARITY_ERR = 1'b0;
`endif

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Byte-oriented UART receiver, 8N1 (optionally 8E1), with a 2-flop input synchronizer, mid-bit start validation, stop-bit framing check and a one-entry holding register with a valid/ack handshake. Sits on the serial input pin of the controller and is the receiving end for UART_TX frames. It hands complete bytes to the command-decode logic, which may take an arbitrary time to consume them.

## Interface
- c_CYCLES_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); legal range ≥ 8. H = (c_CYCLES_PER_BIT-1)/2 (integer division) is the half-bit point.
- i_CLK  in  1  system clock; all logic is on the rising edge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_SERIAL_DATA  in  1  asynchronous serial line; idle high.
- i_RX_ACK  in  1  consumer acknowledge; pops the holding register.
- o_DATA_RX  out  8  holding register contents, LSB = first data bit.
- o_RX_DATA_VALID  out  1  level; high while the holding register holds an unconsumed byte.
- o_FRAME_ERR  out  1  one-cycle pulse when the stop bit is sampled low.
- o_PARITY_ERR  out  1  one-cycle pulse on a parity mismatch (see Configuration).
- o_OVERRUN  out  1  one-cycle pulse when a completed byte is dropped.
- o_RX_BUSY  out  1  high in every state except IDLE.

## Operation
- Synchronizer: two flops, both reset to 1. The FSM sees only the stage-2 output s.
- Bit counter: 0..c_CYCLES_PER_BIT-1, cleared on every state change. Bit index: 0..7.
- IDLE: if s==0, go to START.
- START: at cnt==H, resample s. If s==0, go to DATA. If s==1, treat as a glitch and go back to IDLE with no flag raised.
- DATA: at cnt==c_CYCLES_PER_BIT-1, shift s into bit[index], LSB first. After index 7, go to PARITY if it is compiled in, otherwise to STOP.
- STOP: at cnt==c_CYCLES_PER_BIT-1, sample s.
  - s==1 with no parity error: deliver the byte and go to IDLE.
  - s==0: pulse o_FRAME_ERR, do not deliver, go to BREAK.
- BREAK: wait for s==1, then go to IDLE. A held-low line yields exactly one o_FRAME_ERR.
- Deliver:
  - If o_RX_DATA_VALID==0, or i_RX_ACK==1 in the same cycle: load o_DATA_RX and set valid.
  - Otherwise: drop the new byte, keep the old one, and pulse o_OVERRUN.
- Handshake: i_RX_ACK while valid==1 clears valid on the next edge. i_RX_ACK while valid==0 is ignored. o_DATA_RX holds its value after ack until the next delivery.
- Reset (any time, including mid-frame): FSM goes to IDLE; counters and the shift register go to 0. Outputs reset to o_DATA_RX=0x00 and all flags, valid and busy = 0. If the line is held low through reset release, this is taken as a start bit 2 cycles later.

## Timing
- Let k be the first rising edge at which i_SERIAL_DATA is low. Let N = c_CYCLES_PER_BIT and P = 1 if parity is compiled in, else 0.
- START is entered at edge k+2.
- Start bit is resampled at edge k+2+H.
- Data bit i is sampled at edge k+2+H+N·(i+1).
- Stop bit is sampled at edge S = k+2+H+N·(9+P).
- o_RX_DATA_VALID, o_FRAME_ERR, o_PARITY_ERR and o_OVERRUN are registered at edge S, so they are visible for the cycle after S.
- For N=217, P=0: S = k+2063.
- The receiver is back in IDLE after S and can accept a new start bit immediately. The next start is detected 2 cycles after it reaches the pin.
- Back-to-back frames at a matched baud rate are received without loss.

## Configuration
- UART_RX_PARITY_EN
  - Defined: a PARITY state sits between DATA and STOP. One bit, even parity, sampled at cnt==N-1. On mismatch with XOR of the data bits, o_PARITY_ERR pulses at edge S and the byte is not delivered. If the stop bit is also low, both error flags pulse and BREAK is entered.
  - Undefined: no PARITY state; o_PARITY_ERR is tied to 0; the port is kept.

## Test plan
- Send 0xCB, 8N1, N=217, i_RX_ACK low → o_RX_DATA_VALID rises at k+2063, o_DATA_RX=0xCB, no error flags; ack clears valid one cycle later.
- Low pulse of 50 cycles, then line high → no valid, no o_FRAME_ERR; o_RX_BUSY returns to 0 by k+2+H+1; a following 0x55 frame is received correctly.
- Frame 0xA5 with stop bit low, line held low 3 bit times → exactly one o_FRAME_ERR pulse, valid stays 0; a following 0x3C frame is received correctly.
- Frames 0x11 then 0x22 with no ack → o_OVERRUN pulses at the second S, o_DATA_RX stays 0x11. Repeat with i_RX_ACK high in the cycle of the second delivery → no overrun, o_DATA_RX=0x22, valid stays 1.
- Assert i_RESET_n low during data bit 4 of 0xF0 → all outputs 0 immediately. After release with the line high, a new 0x0F frame is received as 0x0F.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → delivered. 0x07 with parity bit 0 → o_PARITY_ERR pulse, no valid.
